// File: rtl/dsp_mac_cascade.sv
// dsp_mac_cascade: pipelined signed multiply-accumulate slice with a cascade
// input, followed by a rounded and saturated narrow output. A chain of slices
// is built by feeding each slice's p_o into the next slice's pc_i.
//
// Ports:
//   clk       rising-edge clock for all logic
//   rst       synchronous active-high reset
//   in_valid  a, b, mode and last are sampled this cycle
//   a         signed multiplicand (A_W bits)
//   b         multiplier (B_W bits), signed when B_SIGNED != 0
//   mode      00 cascade, 01 accumulate, 10 load, 11 accumulate + cascade
//   last      final term of an accumulation; requests a y_o result
//   pc_i      signed cascade input, used on the accumulate stage
//   p_o       registered accumulator / cascade output
//   p_valid   p_o was updated on the preceding edge
//   y_o       rounded, saturated result
//   y_valid   one-cycle pulse when y_o is new
//   y_sat     y_o was clipped; qualified by y_valid
module dsp_mac_cascade #(
  parameter int A_W      = 16,
  parameter int B_W      = 8,
  parameter int B_SIGNED = 0,
  parameter int ACC_W    = 48,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [1:0]       mode,
  input  logic             last,
  input  logic [ACC_W-1:0] pc_i,
  output logic [ACC_W-1:0] p_o,
  output logic             p_valid,
  output logic [OUT_W-1:0] y_o,
  output logic             y_valid,
  output logic             y_sat
);

  typedef enum logic [1:0] {
    MODE_CASC     = 2'b00,
    MODE_ACC      = 2'b01,
    MODE_LOAD     = 2'b10,
    MODE_ACC_CASC = 2'b11
  } mode_e;

  // b is always widened by one bit so signed and unsigned share one multiplier.
  localparam int PROD_W = A_W + B_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [A_W-1:0]   a_r;
  logic        [B_W-1:0]   b_r;
  mode_e                   mode1, mode2;
  logic                    last1, last2, last3;
  logic                    v1, v2, v3;
  logic signed [B_W:0]     b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] mul, p, p_next;
  logic signed [ACC_W:0]   rnd, r, q;

  // Stage 1: input registers; data holds while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      mode1 <= MODE_CASC;
      last1 <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r   <= a;
        b_r   <= b;
        mode1 <= mode_e'(mode);
        last1 <= last;
      end
    end
  end

  // Stage 2: multiply, sign-extended to the accumulator width.
  always_comb begin
    if (B_SIGNED != 0) b_ext = {b_r[B_W-1], b_r};
    else               b_ext = {1'b0, b_r};
    prod = a_r * b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul   <= '0;
      mode2 <= MODE_CASC;
      last2 <= 1'b0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        mul   <= ACC_W'(prod);
        mode2 <= mode1;
        last2 <= last1;
      end
    end
  end

  // Stage 3: accumulate; sums wrap modulo 2^ACC_W.
  always_comb begin
    p_next = '0;
    unique case (mode2)
      MODE_CASC:     p_next = mul + pc_i;
      MODE_ACC:      p_next = p + mul;
      MODE_LOAD:     p_next = mul;
      MODE_ACC_CASC: p_next = p + mul + pc_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      last3 <= 1'b0;
      v3    <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        p     <= p_next;
        last3 <= last2;
      end
    end
  end

  assign p_o     = p;
  assign p_valid = v3;

  // Stage 4: round half-up in ACC_W+1 bits so the round add cannot overflow.
  always_comb begin
    rnd = '0;
    if (SHIFT > 0) rnd[RND_SH] = 1'b1;
    r = {p[ACC_W-1], p} + rnd;
    q = r >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_o     <= '0;
      y_valid <= 1'b0;
      y_sat   <= 1'b0;
    end else begin
      y_valid <= v3 && last3;
      if (v3 && last3) begin
        if (q > Y_MAX) begin
          y_o   <= Y_MAX[OUT_W-1:0];
          y_sat <= 1'b1;
        end else if (q < Y_MIN) begin
          y_o   <= Y_MIN[OUT_W-1:0];
          y_sat <= 1'b1;
        end else begin
          y_o   <= q[OUT_W-1:0];
          y_sat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_cascade.sv
// Scoreboard bench for dsp_mac_cascade. Two instances share one stimulus
// stream: dut0 uses the defaults (unsigned b, 48-bit acc, shift 8) and dut1
// uses signed b, a 25-bit accumulator and shift 0. A plain-arithmetic model
// computes each term's expected p and y at issue time; negedge monitors pop
// and compare whenever an instance presents p_valid / y_valid.
module tb_dsp_mac_cascade;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [7:0]  b;
  logic [1:0]  mode;
  logic        last;
  logic [47:0] pc_i0, p_o0;
  logic [24:0] pc_i1, p_o1;
  logic        p_valid0, p_valid1, y_valid0, y_valid1, y_sat0, y_sat1;
  logic [15:0] y_o0, y_o1;

  dsp_mac_cascade dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .last(last),
    .pc_i(pc_i0), .p_o(p_o0), .p_valid(p_valid0), .y_o(y_o0), .y_valid(y_valid0), .y_sat(y_sat0)
  );

  dsp_mac_cascade #(.B_SIGNED(1), .ACC_W(25), .SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .last(last),
    .pc_i(pc_i1), .p_o(p_o1), .p_valid(p_valid1), .y_o(y_o1), .y_valid(y_valid1), .y_sat(y_sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint y;
    bit     sat;
  } yexp_t;

  longint pq0[$], pq1[$];
  yexp_t  yq0[$], yq1[$];

  int     vectors = 0;
  int     miscompares = 0;

  // Reference model state and per-instance configuration.
  longint p_m[2];
  int     acc_w[2] = '{48, 25};
  int     shft[2]  = '{8, 0};
  bit     bsg[2]   = '{1'b0, 1'b1};
  logic [47:0] pc_n1, pc_n2;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic model_issue(input logic [15:0] av, input logic [7:0] bv, input logic [1:0] md,
                             input bit lst, input logic [47:0] pcv);
    for (int unsigned i = 0; i < 2; i++) begin
      longint asg, bx, mul, pcs, np, rr, qq;
      yexp_t  ye;
      asg = longint'($signed(av));
      bx  = bsg[i] ? longint'($signed(bv)) : longint'(bv);
      mul = asg * bx;
      pcs = sx(longint'(pcv), acc_w[i]);
      case (md)
        2'b00:   np = mul + pcs;
        2'b01:   np = p_m[i] + mul;
        2'b10:   np = mul;
        default: np = p_m[i] + mul + pcs;
      endcase
      np = sx(np, acc_w[i]);
      p_m[i] = np;
      if (i == 0) pq0.push_back(np); else pq1.push_back(np);
      if (lst) begin
        rr = np;
        if (shft[i] > 0) rr = rr + (longint'(1) <<< (shft[i] - 1));
        qq = rr >>> shft[i];
        if (qq > 32767) begin
          ye.y = 32767;  ye.sat = 1'b1;
        end else if (qq < -32768) begin
          ye.y = -32768; ye.sat = 1'b1;
        end else begin
          ye.y = qq;     ye.sat = 1'b0;
        end
        if (i == 0) yq0.push_back(ye); else yq1.push_back(ye);
      end
    end
  endtask

  // One cycle: set inputs, wait for the edge, return 1 time unit after it.
  // pcv belongs to this term and reaches pc_i two cycles later, when the
  // term is in the accumulate stage.
  task automatic drive(input bit vld, input logic [15:0] av, input logic [7:0] bv,
                       input logic [1:0] md, input bit lst, input logic [47:0] pcv, input bit r);
    rst = r; in_valid = vld; a = av; b = bv; mode = md; last = lst;
    pc_i0 = pc_n2;
    pc_i1 = pc_n2[24:0];
    pc_n2 = pc_n1;
    pc_n1 = pcv;
    if (r) begin
      p_m[0] = 0;
      p_m[1] = 0;
    end else if (vld) begin
      model_issue(av, bv, md, lst, pcv);
    end
    @(posedge clk);
    #1;
    if (r) begin
      pq0.delete(); pq1.delete(); yq0.delete(); yq1.delete();
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      drive(1'b0, 16'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), {16'($urandom), 32'($urandom)}, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " p_o0"},     longint'(p_o0), 0);
    check({tag, " p_valid0"}, longint'(p_valid0), 0);
    check({tag, " y_o0"},     longint'(y_o0), 0);
    check({tag, " y_valid0"}, longint'(y_valid0), 0);
    check({tag, " y_sat0"},   longint'(y_sat0), 0);
    check({tag, " p_o1"},     longint'(p_o1), 0);
    check({tag, " y_valid1"}, longint'(y_valid1), 0);
  endtask

  // Monitors: compare on every presented output.
  always @(negedge clk) begin
    if (p_valid0) begin
      if (pq0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL p0 unexpected: got %0d expected none", longint'($signed(p_o0)));
      end else check("p0", longint'($signed(p_o0)), pq0.pop_front());
    end
    if (y_valid0) begin
      if (yq0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL y0 unexpected: got %0d expected none", longint'($signed(y_o0)));
      end else begin
        yexp_t e;
        e = yq0.pop_front();
        check("y0", longint'($signed(y_o0)), e.y);
        check("y_sat0", longint'(y_sat0), longint'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (p_valid1) begin
      if (pq1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL p1 unexpected: got %0d expected none", longint'($signed(p_o1)));
      end else check("p1", longint'($signed(p_o1)), pq1.pop_front());
    end
    if (y_valid1) begin
      if (yq1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL y1 unexpected: got %0d expected none", longint'($signed(y_o1)));
      end else begin
        yexp_t e;
        e = yq1.pop_front();
        check("y1", longint'($signed(y_o1)), e.y);
        check("y_sat1", longint'(y_sat1), longint'(e.sat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pc_n1 = '0;
    pc_n2 = '0;
    p_m[0] = 0;
    p_m[1] = 0;

    // Reset state.
    for (int unsigned k = 0; k < 3; k++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    check_zero("reset");

    // LOAD -3 x 200 with last.
    drive(1'b1, 16'hFFFD, 8'd200, 2'b10, 1'b1, '0, 1'b0);
    idle(2);
    check("load p_o0", longint'($signed(p_o0)), -600);
    idle(1);
    check("load y_o0", longint'($signed(y_o0)), -2);
    check("load y_valid0", longint'(y_valid0), 1);
    check("load y_sat0", longint'(y_sat0), 0);
    idle(2);

    // Accumulation chain, back-to-back.
    drive(1'b1, 16'd1000, 8'd100, 2'b10, 1'b0, '0, 1'b0);
    drive(1'b1, 16'd1000, 8'd100, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b1, 16'd1000, 8'd100, 2'b01, 1'b1, '0, 1'b0);
    check("acc p1st", longint'($signed(p_o0)), 100000);
    idle(1);
    check("acc p2nd", longint'($signed(p_o0)), 200000);
    idle(1);
    check("acc p3rd", longint'($signed(p_o0)), 300000);
    idle(1);
    check("acc y_o0", longint'($signed(y_o0)), 1172);
    check("acc y_valid0", longint'(y_valid0), 1);
    idle(2);

    // Cascade with pc_i = 0x10000.
    drive(1'b1, 16'd2, 8'd3, 2'b00, 1'b0, 48'h0000_0001_0000, 1'b0);
    idle(2);
    check("casc p_o0", longint'($signed(p_o0)), 65542);
    idle(2);

    // Saturation on dut1 (shift 0, signed b).
    drive(1'b1, 16'h7FFF, 8'd127, 2'b10, 1'b1, '0, 1'b0);
    drive(1'b1, 16'h8000, 8'd127, 2'b10, 1'b1, '0, 1'b0);
    idle(2);
    check("sat hi y_o1", longint'($signed(y_o1)), 32767);
    check("sat hi y_sat1", longint'(y_sat1), 1);
    idle(1);
    check("sat lo y_o1", longint'($signed(y_o1)), -32768);
    check("sat lo y_sat1", longint'(y_sat1), 1);
    idle(2);

    // Signed b = -1.
    drive(1'b1, 16'd5, 8'hFF, 2'b10, 1'b0, '0, 1'b0);
    idle(2);
    check("bsigned p_o1", longint'($signed(p_o1)), -5);
    check("bunsigned p_o0", longint'($signed(p_o0)), 1275);
    idle(2);

    // Wrap in the 25-bit accumulator.
    drive(1'b1, 16'd0, 8'd0, 2'b00, 1'b0, 48'h0000_00FF_FFFF, 1'b0);
    drive(1'b1, 16'd1, 8'd1, 2'b01, 1'b0, '0, 1'b0);
    idle(1);
    check("wrap pre p_o1", longint'($signed(p_o1)), 16777215);
    idle(1);
    check("wrap p_o1", longint'($signed(p_o1)), -16777216);
    idle(2);

    // Reset with three ACC terms in flight; in_valid during reset is ignored.
    drive(1'b1, 16'd300, 8'd20, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b1, 16'd300, 8'd20, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b1, 16'd300, 8'd20, 2'b01, 1'b1, '0, 1'b0);
    drive(1'b1, 16'd9, 8'd9, 2'b01, 1'b1, '0, 1'b1);
    check_zero("midreset");
    drive(1'b1, 16'd7, 8'd1, 2'b01, 1'b0, '0, 1'b0);
    idle(2);
    check("post-reset p_o0", longint'($signed(p_o0)), 7);
    check("post-reset p_o1", longint'($signed(p_o1)), 7);
    idle(2);

    // Randomized traffic, including occasional resets and extreme operands.
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h80;
      drive($urandom_range(0, 3) != 0, ra, rb, 2'($urandom), $urandom_range(0, 3) == 0,
            {16'($urandom), 32'($urandom)}, $urandom_range(0, 299) == 0);
    end

    idle(8);
    check("drain pq0", longint'(pq0.size()), 0);
    check("drain pq1", longint'(pq1.size()), 0);
    check("drain yq0", longint'(yq0.size()), 0);
    check("drain yq1", longint'(yq1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
